// File: rtl/delay_rmw_sweep_driver.sv
// Sweeps a run of addresses over an 8x32 RMW memory, XOR-summing pre-write words.
// Optional VERIFY re-read phase is enabled by defining DELAY_RMW_VERIFY_EN.
module delay_rmw_sweep_driver (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_start,
  input  logic [2:0]  io_base,
  input  logic [3:0]  io_count,
  output logic        io_busy,
  output logic        io_done,
  output logic [31:0] io_checksum,
  output logic        io_error,
  output logic        mem_enable,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
`ifdef DELAY_RMW_VERIFY_EN
    S_VERIFY,
`endif
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cur_addr, cur_addr_nxt;
  logic [CNT_W-1:0]    remaining, remaining_nxt;
  logic [CNT_W-1:0]    eff_count;
  logic [DATA_W-1:0]   checksum_nxt;
  logic [DATA_W-1:0]   addr_nxt;
  logic                advance;
`ifdef DELAY_RMW_VERIFY_EN
  localparam logic [DATA_W-1:0] KEEP_MASK = 32'h0000_ffff;
  logic [DATA_W-1:0]   snapshot, snapshot_nxt;
  logic                error_nxt;
`endif

  // Zero and anything above the memory depth both mean a full sweep.
  assign eff_count = ((io_count == '0) || (io_count > CNT_W'(DEPTH))) ? CNT_W'(DEPTH) : io_count;

  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    checksum_nxt  = io_checksum;
    advance       = 1'b0;
`ifdef DELAY_RMW_VERIFY_EN
    snapshot_nxt  = snapshot;
    error_nxt     = io_error;
`endif
    case (state)
      S_IDLE: begin
        if (io_start) begin
          cur_addr_nxt  = io_base;
          remaining_nxt = eff_count;
          checksum_nxt  = '0;
`ifdef DELAY_RMW_VERIFY_EN
          snapshot_nxt  = '0;
          error_nxt     = 1'b0;
`endif
          state_nxt     = S_READ;
        end
      end
      S_READ: begin
        checksum_nxt = io_checksum ^ mem_rdata;
`ifdef DELAY_RMW_VERIFY_EN
        snapshot_nxt = mem_rdata;
`endif
        state_nxt    = S_WRITE;
      end
      S_WRITE: begin
`ifdef DELAY_RMW_VERIFY_EN
        state_nxt = S_VERIFY;
`else
        advance   = 1'b1;
`endif
      end
`ifdef DELAY_RMW_VERIFY_EN
      S_VERIFY: begin
        if (mem_rdata != (snapshot & KEEP_MASK)) error_nxt = 1'b1;
        advance = 1'b1;
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Last phase of each address: step the pointer and decide between next address and DONE.
    if (advance) begin
      cur_addr_nxt  = cur_addr + 3'd1;
      remaining_nxt = remaining - 4'd1;
      state_nxt     = (remaining == 4'd1) ? S_DONE : S_READ;
    end

    addr_nxt = '0;
    if ((state_nxt == S_READ) || (state_nxt == S_WRITE)
`ifdef DELAY_RMW_VERIFY_EN
        || (state_nxt == S_VERIFY)
`endif
       ) addr_nxt = DATA_W'(cur_addr_nxt);
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      io_checksum <= '0;
      io_busy     <= 1'b0;
      io_done     <= 1'b0;
      mem_enable  <= 1'b0;
      mem_addr    <= '0;
    end else begin
      state       <= state_nxt;
      cur_addr    <= cur_addr_nxt;
      remaining   <= remaining_nxt;
      io_checksum <= checksum_nxt;
      io_busy     <= (state_nxt != S_IDLE);
      io_done     <= (state_nxt == S_DONE);
      mem_enable  <= (state_nxt == S_WRITE);
      mem_addr    <= addr_nxt;
    end
  end

`ifdef DELAY_RMW_VERIFY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snapshot <= '0;
      io_error <= 1'b0;
    end else begin
      snapshot <= snapshot_nxt;
      io_error <= error_nxt;
    end
  end
`else
  assign io_error = 1'b0;
`endif

endmodule
